// File: rtl/packet_generator_mc.sv
// packet_generator_mc
//
// Multi-channel packet generator. A round-robin arbiter picks one requesting,
// enabled source channel per cycle. The winner's payload is framed as
// {ch_id, seq, payload, parity} into a registered valid/ready output stage.
// Each channel has its own sequence counter. Packets accepted downstream are
// counted in pkt_count.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   ch_en      in   per-channel enable mask
//   src_valid  in   per-channel payload valid
//   src_data   in   channel i payload at [i*PAYLOAD_W +: PAYLOAD_W]
//   src_ready  out  one-hot grant (combinational), zero when the slot is busy
//   dd_ready   in   downstream ready
//   dd_valid   out  packet valid (registered)
//   packet     out  {ch_id, seq, payload, parity} (registered)
//   pkt_count  out  delivered-packet counter, wraps

module packet_generator_mc #(
    parameter int NUM_CH    = 4,
    parameter int SEQ_W     = 2,
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 16,
    localparam int CH_W     = $clog2(NUM_CH),
    localparam int PKT_W    = CH_W + SEQ_W + PAYLOAD_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH-1:0]             src_valid,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   src_data,
    output logic [NUM_CH-1:0]             src_ready,
    input  logic                          dd_ready,
    output logic                          dd_valid,
    output logic [PKT_W-1:0]              packet,
    output logic [CNT_W-1:0]              pkt_count
);

    logic [CH_W-1:0]      last_grant;
    logic [SEQ_W-1:0]     seq [NUM_CH];

    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    grant_oh;
    logic [CH_W-1:0]      grant_idx;
    logic [CH_W-1:0]      idx_hi;
    logic [CH_W-1:0]      idx_lo;
    logic                 found_hi;
    logic                 found_lo;
    logic                 slot_free;
    logic                 transfer;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [PKT_W-2:0]     pkt_upper;

    assign req       = src_valid & ch_en;
    assign slot_free = !dd_valid || dd_ready;

    // Round robin without modulo arithmetic: the lowest requester above
    // last_grant wins; if there is none, the search wraps to the lowest
    // requester overall. The loop runs downward so that the last hit is the
    // lowest index.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        grant_oh = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_lo   = CH_W'(i);
                found_lo = 1'b1;
                if (i > int'(last_grant)) begin
                    idx_hi   = CH_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        if (found_lo) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign transfer    = !rst && slot_free && found_lo;
    assign src_ready   = transfer ? grant_oh : '0;
    assign sel_payload = src_data[grant_idx*PAYLOAD_W +: PAYLOAD_W];
    assign pkt_upper   = {grant_idx, seq[grant_idx], sel_payload};

    always_ff @(posedge clk) begin
        if (rst) begin
            dd_valid   <= 1'b0;
            packet     <= '0;
            pkt_count  <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                seq[i] <= '0;
            end
        end else begin
            if (dd_valid && dd_ready) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (transfer) begin
                // Even parity: the XOR of the whole packet is zero.
                packet          <= {pkt_upper, ^pkt_upper};
                dd_valid        <= 1'b1;
                seq[grant_idx]  <= seq[grant_idx] + 1'b1;
                last_grant      <= grant_idx;
            end else if (dd_ready) begin
                dd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_generator_mc.sv
module tb_packet_generator_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_en;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_ready;
    logic        dd_ready;
    logic        dd_valid;
    logic [12:0] packet;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_err = 0;

    packet_generator_mc dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .dd_ready  (dd_ready),
        .dd_valid  (dd_valid),
        .packet    (packet),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference framing: {ch, seq, payload, even parity}
    function automatic logic [12:0] mk(input int ch, input int sq, input logic [7:0] pl);
        logic [11:0] u;
        u = {2'(ch), 2'(sq), pl};
        return {u, ^u};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pl [4];

    initial begin
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;

        // Reset with requests present: no grants while rst is high
        rst = 1'b1; ch_en = 4'b1111; src_valid = 4'b1111; src_data = 32'h44332211; dd_ready = 1'b0;
        cyc(); cyc();
        check("rst_src_ready", 32'(src_ready), 32'h0);
        check("rst_dd_valid", 32'(dd_valid), 32'h0);
        check("rst_packet", 32'(packet), 32'h0);
        check("rst_count", 32'(pkt_count), 32'h0);

        // Single channel 1, payload A5
        src_valid = 4'b0010; src_data = 32'h0000A500; dd_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("single_src_ready", 32'(src_ready), 32'h2);
        cyc();
        check("single_dd_valid", 32'(dd_valid), 32'h1);
        check("single_packet", 32'(packet), 32'h094B);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("single_seq_pkt", 32'(packet), 32'(mk(1, k % 4, 8'hA5)));
            check("single_seq_valid", 32'(dd_valid), 32'h1);
        end
        check("single_count4", 32'(pkt_count), 32'd4);
        src_valid = 4'b0000;
        cyc();
        check("single_count5", 32'(pkt_count), 32'd5);
        check("single_drain_valid", 32'(dd_valid), 32'h0);

        // Round robin from reset, all channels requesting
        rst = 1'b1; src_data = 32'h44332211;
        cyc();
        rst = 1'b0; src_valid = 4'b1111;
        #1;
        check("rr_first_grant", 32'(src_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("rr_packet", 32'(packet), 32'(mk(k % 4, k / 4, pl[k % 4])));
            check("rr_next_grant", 32'(src_ready), 32'(4'b0001 << ((k + 1) % 4)));
            check("rr_count", 32'(pkt_count), 32'(k));
        end
        src_valid = 4'b0000;
        cyc();
        check("rr_count8", 32'(pkt_count), 32'd8);

        // Backpressure: last_grant=3, every seq=2
        src_valid = 4'b1111; dd_ready = 1'b0;
        #1;
        check("bp_grant", 32'(src_ready), 32'h1);
        cyc();
        check("bp_packet", 32'(packet), 32'(mk(0, 2, 8'h11)));
        for (int k = 0; k < 3; k++) begin
            check("bp_src_ready", 32'(src_ready), 32'h0);
            cyc();
            check("bp_hold_packet", 32'(packet), 32'(mk(0, 2, 8'h11)));
            check("bp_hold_valid", 32'(dd_valid), 32'h1);
            check("bp_hold_count", 32'(pkt_count), 32'd8);
        end
        dd_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(src_ready), 32'h2);
        cyc();
        check("bp_release_packet", 32'(packet), 32'(mk(1, 2, 8'h22)));
        check("bp_release_count", 32'(pkt_count), 32'd9);
        check("bp_release_valid", 32'(dd_valid), 32'h1);
        src_valid = 4'b0000;
        cyc();
        check("bp_drain_count", 32'(pkt_count), 32'd10);

        // Masking: only channels 1 and 3; last_grant=1, seq = {3:2, 2:2, 1:3, 0:3}
        ch_en = 4'b1010; src_valid = 4'b1111;
        #1;
        check("mask_g0", 32'(src_ready), 32'h8);
        cyc();
        check("mask_p0", 32'(packet), 32'(mk(3, 2, 8'h44)));
        check("mask_g1", 32'(src_ready), 32'h2);
        cyc();
        check("mask_p1", 32'(packet), 32'(mk(1, 3, 8'h22)));
        check("mask_g2", 32'(src_ready), 32'h8);
        cyc();
        check("mask_p2", 32'(packet), 32'(mk(3, 3, 8'h44)));
        check("mask_g3", 32'(src_ready), 32'h2);
        cyc();
        check("mask_p3", 32'(packet), 32'(mk(1, 0, 8'h22)));
        check("mask_count", 32'(pkt_count), 32'd13);
        // Disabling everything does not cancel the held packet
        ch_en = 4'b0000;
        #1;
        check("mask_all_off_grant", 32'(src_ready), 32'h0);
        cyc();
        check("mask_off_delivered", 32'(pkt_count), 32'd14);
        check("mask_off_valid", 32'(dd_valid), 32'h0);
        // last_grant stayed 1; channels 0 and 2 kept their seq
        ch_en = 4'b1111; src_valid = 4'b0101;
        #1;
        check("mask_resume_grant", 32'(src_ready), 32'h4);
        cyc();
        check("mask_ch2_pkt", 32'(packet), 32'(mk(2, 2, 8'h33)));
        cyc();
        check("mask_ch0_pkt", 32'(packet), 32'(mk(0, 3, 8'h11)));
        src_valid = 4'b0000;
        cyc();
        check("mask_end_count", 32'(pkt_count), 32'd16);

        // Reset mid-stream with a pending packet
        src_valid = 4'b1111;
        cyc();
        check("mid_pending", 32'(dd_valid), 32'h1);
        rst = 1'b1;
        cyc();
        check("mid_rst_valid", 32'(dd_valid), 32'h0);
        check("mid_rst_count", 32'(pkt_count), 32'h0);
        rst = 1'b0;
        cyc();
        check("mid_first_pkt", 32'(packet), 32'(mk(0, 0, 8'h11)));

        // Counter wrap and parity over 2^16 deliveries
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 65536; k++) begin
            cyc();
            check("wrap_parity", 32'(^packet), 32'h0);
        end
        check("wrap_count_max", 32'(pkt_count), 32'hFFFF);
        src_valid = 4'b0000;
        cyc();
        check("wrap_count_zero", 32'(pkt_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_generator_mc.md
# packet_generator_mc

Multi-channel, parametrised packet generator that sits between several payload sources and a single downstream consumer (dd side). Each cycle a round-robin arbiter grants one requesting, enabled channel. The granted payload is framed into a packet {channel id, per-channel sequence number, payload, even-parity bit} and presented on a registered valid/ready output. It supersedes the single-channel generator: with default parameters the packet is still 13 bits wide, and it adds channel masking, sequence numbering and a delivered-packet counter.

## Interface
- NUM_CH, 4: number of source channels (>=2); CH_W = $clog2(NUM_CH)
- SEQ_W, 2: per-channel sequence counter width
- PAYLOAD_W, 8: payload width per channel
- CNT_W, 16: width of the delivered-packet counter
- PKT_W (derived, not overridable): CH_W+SEQ_W+PAYLOAD_W+1; 13 with defaults
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ch_en  in  NUM_CH  per-channel enable; a disabled channel is never granted
- src_valid  in  NUM_CH  per-channel payload valid
- src_data  in  NUM_CH*PAYLOAD_W  payloads; channel i at [i*PAYLOAD_W +: PAYLOAD_W]
- src_ready  out  NUM_CH  one-hot (or zero) grant; combinational
- dd_ready  in  1  downstream ready
- dd_valid  out  1  packet valid, registered
- packet  out  PKT_W  {ch_id, seq, payload, parity}, MSB first; registered
- pkt_count  out  CNT_W  packets delivered (dd_valid && dd_ready), wraps

## Operation
- slot_free = !dd_valid || dd_ready. Arbitration happens only when slot_free = 1.
- Request vector = src_valid & ch_en. Round-robin arbitration: search starts at last_grant+1 mod NUM_CH, and the first requester found wins.
- src_ready[i] = 1 only for the winner, and only when slot_free = 1. Otherwise src_ready = 0.
- A source transfer happens when src_valid[i] && src_ready[i]. On that clock edge:
  - packet <= {i, seq[i], src_data[i], p}, where p = ^(upper PKT_W-1 bits), so the XOR of the whole packet is 0.
  - dd_valid <= 1.
  - seq[i] <= seq[i]+1, wrapping at 2^SEQ_W.
  - last_grant <= i.
- If slot_free = 1 with no transfer and dd_ready = 1, dd_valid <= 0. packet keeps its last value.
- While dd_valid = 1 && dd_ready = 0, packet and dd_valid hold stable.
- pkt_count increments on each dd_valid && dd_ready, wrapping at 2^CNT_W.
- seq counters advance only for their own channel, and only on a source transfer, never on delivery.
- Clearing ch_en[i] while a packet from channel i is already in the output register does not cancel that packet.
- Reset values:
  - dd_valid = 0
  - packet = 0
  - pkt_count = 0
  - all seq = 0
  - last_grant = NUM_CH-1, so channel 0 has first priority
  - src_ready = 0 while rst = 1

## Timing
- Latency: source transfer in cycle N gives dd_valid/packet in cycle N+1.
- Throughput: one packet per cycle while dd_ready = 1. Back-to-back transfers are allowed because the slot frees in the same cycle the consumer accepts.
- Simultaneous delivery and new transfer in one cycle: pkt_count increments, packet is replaced, and dd_valid stays 1.
- src_ready depends combinationally on src_valid, ch_en, dd_valid and dd_ready. No combinational path exists from any input to dd_valid or packet.
- rst asserted mid-operation: a pending packet is dropped without being counted, and sequence numbers restart at 0 on the first cycle after rst deasserts.
- All requesters masked or idle: src_ready = 0 and last_grant is unchanged.

## Test plan
- Single channel, defaults: ch_en=4'b1111, src_valid=4'b0010, src_data[1]=8'hA5, dd_ready=1.
  - Required: src_ready=4'b0010; next cycle dd_valid=1, packet=13'h094B.
  - Over 5 accepted packets, seq runs 0,1,2,3,0.
- Round robin: src_valid=4'b1111 held, dd_ready=1 from reset.
  - Required: grant order 0,1,2,3,0,1,…, one packet per cycle.
  - pkt_count = 8 after 8 deliveries.
- Backpressure: a packet is pending and dd_ready=0 for 3 cycles.
  - Required: packet and dd_valid are stable, src_ready=0, and no seq change.
  - On dd_ready=1, that packet is delivered and the next grant issues in the same cycle.
- Masking: ch_en=4'b1010 and src_valid=4'b1111.
  - Required: only channels 1 and 3 are granted, alternating.
  - Channels 0 and 2 keep seq=0.
- Reset mid-stream: assert rst for 1 cycle while dd_valid=1.
  - Required: the next cycle shows dd_valid=0 and pkt_count=0.
  - The first packet afterwards is from channel 0 with seq=0.
- Wrap/parity: 2^CNT_W deliveries wrap pkt_count to 0.
  - Every delivered packet satisfies ^packet == 0.
